// File: rtl/secuenciador_de_melodia_if.sv
// Bus between the score controller (master) and the melody sequencer (slave):
// score RAM write port, playback control and the tone-generator outputs.
interface secuenciador_de_melodia_if #(
    parameter int ANCHO_DIR  = 7,
    parameter int ANCHO_FREC = 10,
    parameter int ANCHO_DUR  = 4
);
    logic                  esc_en;
    logic [ANCHO_DIR-1:0]  esc_dir;
    logic [ANCHO_FREC-1:0] esc_frec;
    logic [ANCHO_DUR-1:0]  esc_dur;
    logic [ANCHO_DIR-1:0]  longitud;
    logic                  iniciar;
    logic                  detener;
    logic                  repetir;
    logic [ANCHO_FREC-1:0] frecuencia;
    logic [ANCHO_DIR-1:0]  indice;
    logic                  ocupado;
    logic                  fin;

    modport master (
        output esc_en, esc_dir, esc_frec, esc_dur, longitud, iniciar, detener, repetir,
        input  frecuencia, indice, ocupado, fin
    );

    modport slave (
        input  esc_en, esc_dir, esc_frec, esc_dur, longitud, iniciar, detener, repetir,
        output frecuencia, indice, ocupado, fin
    );
endinterface

// File: rtl/secuenciador_de_melodia.sv
// Programmable melody sequencer: plays a score of frequency/duration entries
// from an internal RAM, with start/stop/loop control and a runtime score length.
// Optional macro ARTICULACION_EN: silences the last tempo tick of every note
// whose duration field is at least 1, leaving total note time unchanged.
module secuenciador_de_melodia #(
    parameter int PROFUNDIDAD = 128,
    parameter int ANCHO_DIR   = 7,
    parameter int ANCHO_FREC  = 10,
    parameter int ANCHO_DUR   = 4,
    parameter int CICLOS_TICK = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    secuenciador_de_melodia_if.slave      bus
);
    localparam int ANCHO_PRE = $clog2(CICLOS_TICK);
    localparam int ANCHO_MEM = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
    localparam logic [ANCHO_PRE-1:0] PRE_MAX = ANCHO_PRE'(CICLOS_TICK - 1);
    localparam logic [ANCHO_DIR:0]   LIMITE  = (ANCHO_DIR + 1)'(PROFUNDIDAD);
    localparam logic [ANCHO_DIR-1:0] IDX_MAX = ANCHO_DIR'(PROFUNDIDAD - 1);

    localparam logic [1:0] REPOSO  = 2'd0;
    localparam logic [1:0] CARGA   = 2'd1;
    localparam logic [1:0] SONANDO = 2'd2;

    logic [ANCHO_FREC-1:0] r_mem_frec [PROFUNDIDAD];
    logic [ANCHO_DUR-1:0]  r_mem_dur  [PROFUNDIDAD];

    logic [1:0]            r_estado;
    logic [ANCHO_DIR-1:0]  r_indice;
    logic [ANCHO_DIR-1:0]  r_long_lat;
    logic [ANCHO_FREC-1:0] r_frec;
    logic [ANCHO_DUR-1:0]  r_dur;
    logic [ANCHO_DUR-1:0]  r_ticks;
    logic [ANCHO_PRE-1:0]  r_pre;
    logic                  r_fin;

    logic                  w_esc_ok;
    logic [ANCHO_MEM-1:0]  w_dir_esc;
    logic [ANCHO_MEM-1:0]  w_dir_lec;
    logic [ANCHO_DIR-1:0]  w_long_sat;
    logic                  w_tick;
    logic                  w_fin_nota;
    logic                  w_ultima;

    // Out-of-range write addresses are dropped rather than aliased into the RAM.
    assign w_esc_ok   = bus.esc_en && ({1'b0, bus.esc_dir} < LIMITE);
    assign w_dir_esc  = bus.esc_dir[ANCHO_MEM-1:0];
    assign w_dir_lec  = r_indice[ANCHO_MEM-1:0];
    assign w_long_sat = ({1'b0, bus.longitud} >= LIMITE) ? IDX_MAX : bus.longitud;
    assign w_tick     = (r_pre == PRE_MAX);
    assign w_fin_nota = w_tick && (r_ticks == r_dur);
    assign w_ultima   = (r_indice == r_long_lat);

    // Score RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_esc_ok) begin
            r_mem_frec[w_dir_esc] <= bus.esc_frec;
            r_mem_dur[w_dir_esc]  <= bus.esc_dur;
        end
    end

    // Playback FSM; the RAM read is registered directly into frecuencia/dur,
    // so a same-cycle write to the address being loaded yields the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado   <= REPOSO;
            r_indice   <= '0;
            r_long_lat <= '0;
            r_frec     <= '0;
            r_dur      <= '0;
            r_ticks    <= '0;
            r_pre      <= '0;
            r_fin      <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (bus.iniciar && !bus.detener) begin
                        r_estado   <= CARGA;
                        r_indice   <= '0;
                        r_long_lat <= w_long_sat;
                    end
                end
                CARGA: begin
                    if (bus.detener) begin
                        r_estado <= REPOSO;
                        r_frec   <= '0;
                        r_indice <= '0;
                    end else begin
                        r_estado <= SONANDO;
                        r_frec   <= r_mem_frec[w_dir_lec];
                        r_dur    <= r_mem_dur[w_dir_lec];
                        r_pre    <= '0;
                        r_ticks  <= '0;
                    end
                end
                SONANDO: begin
                    if (bus.detener) begin
                        r_estado <= REPOSO;
                        r_frec   <= '0;
                        r_indice <= '0;
                    end else begin
                        if (w_tick) begin
                            r_pre   <= '0;
                            r_ticks <= r_ticks + 1'b1;
                        end else begin
                            r_pre <= r_pre + 1'b1;
                        end
`ifdef ARTICULACION_EN
                        // Entering the final tick of a multi-tick note: go silent.
                        if (w_tick && (r_dur != '0) && (r_ticks == r_dur - 1'b1)) begin
                            r_frec <= '0;
                        end
`endif
                        if (w_fin_nota) begin
                            if (!w_ultima) begin
                                r_indice <= r_indice + 1'b1;
                                r_estado <= CARGA;
                            end else if (bus.repetir) begin
                                r_indice <= '0;
                                r_estado <= CARGA;
                            end else begin
                                r_estado <= REPOSO;
                                r_frec   <= '0;
                                r_fin    <= 1'b1;
                            end
                        end
                    end
                end
                default: r_estado <= REPOSO;
            endcase
        end
    end

    assign bus.frecuencia = r_frec;
    assign bus.indice     = r_indice;
    assign bus.ocupado    = (r_estado != REPOSO);
    assign bus.fin        = r_fin;
endmodule
